alu_slice_serial: RTL and testbench

- Parametrised multi-cycle ALU that replaces ripple-of-1-bit-slices with a WIDTH-bit operand path processed SLICE bits per clock, LSB chunk first.
- Carry is held in a register between chunks.
- Adds XOR, a valid/ready handshake on both sides, carry-in for chained adds, and status flags.
- Sits between the operand register file and the result writeback in the datapath.

---
 rtl/alu_slice_serial_pkg.sv | 23 ++
 rtl/alu_slice_serial_if.sv | 51 +++++
 rtl/alu_slice_serial_slice_n.sv | 51 +++++
 rtl/alu_slice_serial.sv | 163 ++++++++++++++++
 tb/tb_alu_slice_serial.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_slice_serial_pkg.sv
// alu_pkg: shared definitions for the serial slice ALU.
//   - op code constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR)
//   - FSM state enum (IDLE, RUN, DONE)
//   - is_arith(): true for the ops that use and update the carry chain
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_slice_serial_if.sv
// alu_slice_serial_if: request/result bundle of the serial slice ALU.
//   Request side : in_valid, in_ready, a, b, op, cin
//   Result side  : out_valid, out_ready, result, carry
//                  (+ zero, negative, overflow when ALU_FLAGS_EN is defined)
// Modports: master = operand source / result consumer, slave = the ALU.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The source holds its payload stable while valid is high and
// ready is low; the ALU holds result/carry/flags stable while out_valid is
// high and out_ready is low.
interface alu_slice_serial_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, result, carry, zero, negative, overflow
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, result, carry, zero, negative, overflow
  );
`else
  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, result, carry
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, result, carry
  );
`endif

endinterface

// File: rtl/alu_slice_serial_slice_n.sv
// alu_slice_n: combinational SLICE-bit logic/add-sub unit.
//   a_i, b_i  : operand chunks
//   op_i      : op code (alu_pkg constants)
//   cin_i     : carry into bit 0 of the chunk
//   y_o       : chunk result (0 for illegal op codes)
//   cout_o    : carry out of the chunk MSB
//   cmsb_o    : carry into the chunk MSB (used for signed overflow)
module alu_slice_n
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] y_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] bx;
  logic [SLICE-1:0] sum;

  always_comb begin
    // ADD and SUB share one adder: op LSB inverts B; the +1 of SUB comes in
    // through the carry register, which is preset to 1 on a SUB accept.
    bx   = b_i ^ {SLICE{op_i[0]}};
    c    = '0;
    sum  = '0;
    c[0] = cin_i;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = a_i[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a_i[i] & bx[i]) | (a_i[i] & c[i]) | (bx[i] & c[i]);
    end

    y_o = '0;
    case (op_i)
      OP_AND:         y_o = a_i & b_i;
      OP_OR:          y_o = a_i | b_i;
      OP_XOR:         y_o = a_i ^ b_i;
      OP_ADD, OP_SUB: y_o = sum;
      default:        y_o = '0;
    endcase

    cout_o = c[SLICE];
    cmsb_o = c[SLICE-1];
  end

endmodule

// File: rtl/alu_slice_serial.sv
// alu_slice_serial: multi-cycle ALU processing a WIDTH-bit operation SLICE
// bits per clock, LSB chunk first, with the carry held in a register.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/a/b/op/cin request,
//                  out_valid/out_ready/result/carry response
//                  (+ zero/negative/overflow when ALU_FLAGS_EN is defined)
//   dbg_state_o  : current FSM state
// Optional feature macro: ALU_FLAGS_EN (registered status flags).
// Timing: out_valid rises NSLICE clocks after the accept edge; one op per
// NSLICE+2 clocks when the consumer is always ready.
module alu_slice_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_slice_serial_if.slave   bus,
  output state_e              dbg_state_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("alu_slice_serial: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       op_q;
  logic             c_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
`ifdef ALU_FLAGS_EN
  logic             zero_q;
  logic             negative_q;
  logic             overflow_q;
`endif

  logic [SLICE-1:0] s_y;
  logic             s_cout;
  logic             s_cmsb;
  logic [WIDTH-1:0] sh_d;
  logic             arith;

  alu_slice_n #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i    (a_q[SLICE-1:0]),
    .b_i    (b_q[SLICE-1:0]),
    .op_i   (op_q),
    .cin_i  (c_q),
    .y_o    (s_y),
    .cout_o (s_cout),
    .cmsb_o (s_cmsb)
  );

  // Each chunk result enters at the top so that after NSLICE shifts the
  // first (LSB) chunk has reached bit 0.
  generate
    if (SLICE == WIDTH) begin : g_full
      assign sh_d = s_y;
    end else begin : g_part
      assign sh_d = {s_y, sh_q[WIDTH-1:SLICE]};
    end
  endgenerate

  assign arith = is_arith(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sh_q        <= '0;
      result_q    <= '0;
      op_q        <= '0;
      c_q         <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
`ifdef ALU_FLAGS_EN
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            op_q       <= bus.op;
            c_q        <= (bus.op == OP_ADD) ? bus.cin : (bus.op == OP_SUB);
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end

        RUN: begin
          sh_q  <= sh_d;
          a_q   <= a_q >> SLICE;
          b_q   <= b_q >> SLICE;
          cnt_q <= cnt_q + CW'(1);
          if (arith) begin
            c_q <= s_cout;
          end
          if (cnt_q == CW'(NSLICE - 1)) begin
            // Last chunk: publish result/carry/flags together with out_valid
            // so they stay untouched while the next op is in RUN.
            result_q    <= sh_d;
            carry_q     <= arith & s_cout;
`ifdef ALU_FLAGS_EN
            zero_q      <= (sh_d == '0);
            negative_q  <= sh_d[WIDTH-1];
            overflow_q  <= arith & (s_cout ^ s_cmsb);
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          // Returning to IDLE first means no accept in the consume cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
`ifdef ALU_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;
`endif
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_slice_serial.sv
// Directed testbench for alu_slice_serial: three instances (SLICE=4, 1, 16)
// share one clock and reset. Flags are checked when ALU_FLAGS_EN is defined.
module tb_alu_slice_serial;
  import alu_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_slice_serial_if #(.WIDTH(W)) if4  ();
  alu_slice_serial_if #(.WIDTH(W)) if1  ();
  alu_slice_serial_if #(.WIDTH(W)) if16 ();

  state_e st4, st1, st16;

  alu_slice_serial #(.WIDTH(W), .SLICE(4)) u4 (
    .clk (clk), .rst_n (rst_n), .bus (if4.slave), .dbg_state_o (st4)
  );
  alu_slice_serial #(.WIDTH(W), .SLICE(1)) u1 (
    .clk (clk), .rst_n (rst_n), .bus (if1.slave), .dbg_state_o (st1)
  );
  alu_slice_serial #(.WIDTH(W), .SLICE(16)) u16 (
    .clk (clk), .rst_n (rst_n), .bus (if16.slave), .dbg_state_o (st16)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];   // {carry, result}

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int sel, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op, input logic cin);
    case (sel)
      4: begin if4.in_valid = v; if4.a = a; if4.b = b; if4.op = op; if4.cin = cin; end
      1: begin if1.in_valid = v; if1.a = a; if1.b = b; if1.op = op; if1.cin = cin; end
      default: begin
        if16.in_valid = v; if16.a = a; if16.b = b; if16.op = op; if16.cin = cin;
      end
    endcase
  endtask

  task automatic set_ordy(input int sel, input logic r);
    case (sel)
      4:       if4.out_ready  = r;
      1:       if1.out_ready  = r;
      default: if16.out_ready = r;
    endcase
  endtask

  task automatic get_out(input int sel, output logic ov, output logic ir,
                         output logic [W-1:0] res, output logic cy,
                         output state_e st, output logic [2:0] fl);
    fl = 3'b000;
    case (sel)
      4: begin
        ov = if4.out_valid; ir = if4.in_ready; res = if4.result; cy = if4.carry; st = st4;
`ifdef ALU_FLAGS_EN
        fl = {if4.zero, if4.negative, if4.overflow};
`endif
      end
      1: begin
        ov = if1.out_valid; ir = if1.in_ready; res = if1.result; cy = if1.carry; st = st1;
`ifdef ALU_FLAGS_EN
        fl = {if1.zero, if1.negative, if1.overflow};
`endif
      end
      default: begin
        ov = if16.out_valid; ir = if16.in_ready; res = if16.result; cy = if16.carry; st = st16;
`ifdef ALU_FLAGS_EN
        fl = {if16.zero, if16.negative, if16.overflow};
`endif
      end
    endcase
  endtask

  // Present a request in IDLE; returns #1 after the accept edge.
  task automatic issue(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic cin,
                       input logic [W-1:0] exp_res, input logic exp_cy);
    exp_q.push_back({exp_cy, exp_res});
    set_in(sel, 1'b1, a, b, op, cin);
    @(posedge clk); #1;
    set_in(sel, 1'b0, a, b, op, cin);
  endtask

  // Wait (bounded) for out_valid, check latency and payload, then consume.
  task automatic collect(input int sel, input int exp_lat, input logic [2:0] exp_fl,
                         input string tag);
    int k;
    logic ov, ir, cy;
    logic [W-1:0] res;
    logic [2:0] fl;
    logic [W:0] e;
    state_e st;
    k  = 0;
    ov = 1'b0;
    while (k < 64 && !ov) begin
      @(posedge clk); #1;
      k++;
      get_out(sel, ov, ir, res, cy, st, fl);
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_in_ready"}, 32'(ir), 32'(0));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 32'(res), 32'(e[W-1:0]));
      check({tag, "_carry"}, 32'(cy), 32'(e[W]));
    end
`ifdef ALU_FLAGS_EN
    check({tag, "_flags_zno"}, 32'(fl), 32'(exp_fl));
`endif
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    get_out(sel, ov, ir, res, cy, st, fl);
    check({tag, "_consumed_valid"}, 32'(ov), 32'(0));
    check({tag, "_consumed_ready"}, 32'(ir), 32'(1));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         cin;
    logic [W-1:0] res;
    logic         cy;
    logic [2:0]   fl;   // {zero, negative, overflow}
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{16'h7FFF, 16'h0001, OP_ADD, 1'b0, 16'h8000, 1'b0, 3'b011};
    vecs[1]  = '{16'h0005, 16'h0007, OP_SUB, 1'b0, 16'hFFFE, 1'b0, 3'b010};
    vecs[2]  = '{16'h1234, 16'h1234, OP_SUB, 1'b0, 16'h0000, 1'b1, 3'b100};
    vecs[3]  = '{16'hF0F0, 16'h3C3C, OP_AND, 1'b1, 16'h3030, 1'b0, 3'b000};
    vecs[4]  = '{16'hF0F0, 16'h3C3C, OP_OR,  1'b0, 16'hFCFC, 1'b0, 3'b010};
    vecs[5]  = '{16'hF0F0, 16'h3C3C, OP_XOR, 1'b0, 16'hCCCC, 1'b0, 3'b010};
    vecs[6]  = '{16'hFFFF, 16'h0000, OP_ADD, 1'b1, 16'h0000, 1'b1, 3'b100};
    vecs[7]  = '{16'hFFFF, 16'h1234, 3'b101, 1'b1, 16'h0000, 1'b0, 3'b100};
    vecs[8]  = '{16'h8000, 16'h8000, OP_ADD, 1'b0, 16'h0000, 1'b1, 3'b101};
    vecs[9]  = '{16'h0003, 16'h0001, OP_SUB, 1'b1, 16'h0002, 1'b1, 3'b000};
    vecs[10] = '{16'h0001, 16'h0001, OP_ADD, 1'b0, 16'h0002, 1'b0, 3'b000};
  end

  task automatic run_vec(input int sel, input int idx, input int lat, input string tag);
    issue(sel, vecs[idx].a, vecs[idx].b, vecs[idx].op, vecs[idx].cin,
          vecs[idx].res, vecs[idx].cy);
    collect(sel, lat, vecs[idx].fl, tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic ov, ir, cy, seen;
    logic [W-1:0] res;
    logic [2:0] fl;
    state_e st;
    int k;

    rst_n = 1'b0;
    set_in(4, 1'b0, '0, '0, 3'b000, 1'b0);
    set_in(1, 1'b0, '0, '0, 3'b000, 1'b0);
    set_in(16, 1'b0, '0, '0, 3'b000, 1'b0);
    set_ordy(4, 1'b0);
    set_ordy(1, 1'b0);
    set_ordy(16, 1'b0);

    #12;
    get_out(4, ov, ir, res, cy, st, fl);
    check("rst_out_valid", 32'(ov), 32'(0));
    check("rst_in_ready", 32'(ir), 32'(1));
    check("rst_result", 32'(res), 32'(0));
    check("rst_carry", 32'(cy), 32'(0));
    check("rst_state", 32'(st), 32'(IDLE));
`ifdef ALU_FLAGS_EN
    check("rst_flags", 32'(fl), 32'(0));
`endif
    #11;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Main function, SLICE=4
    run_vec(4, 0, 4, "add_ovf");
    run_vec(4, 1, 4, "sub_borrow");
    run_vec(4, 2, 4, "sub_equal");
    run_vec(4, 3, 4, "and");
    run_vec(4, 4, 4, "or");
    run_vec(4, 5, 4, "xor");
    run_vec(4, 6, 4, "add_cin_wrap");
    run_vec(4, 7, 4, "illegal_op");
    run_vec(4, 8, 4, "add_neg_ovf");
    run_vec(4, 9, 4, "sub_cin_ignored");

    // Consumer stalls in DONE while a new request is waiting
    issue(4, 16'h0001, 16'h0002, OP_ADD, 1'b0, 16'h0003, 1'b0);
    k  = 0;
    ov = 1'b0;
    while (k < 64 && !ov) begin
      @(posedge clk); #1;
      k++;
      get_out(4, ov, ir, res, cy, st, fl);
    end
    check("hold_lat", 32'(k), 32'(4));
    set_in(4, 1'b1, 16'h1111, 16'h2222, OP_ADD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      get_out(4, ov, ir, res, cy, st, fl);
      check("hold_result", 32'(res), 32'(16'h0003));
      check("hold_in_ready", 32'(ir), 32'(0));
      check("hold_out_valid", 32'(ov), 32'(1));
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    set_ordy(4, 1'b1);
    @(posedge clk); #1;
    set_ordy(4, 1'b0);
    get_out(4, ov, ir, res, cy, st, fl);
    check("hold_release_state", 32'(st), 32'(IDLE));
    check("hold_release_ready", 32'(ir), 32'(1));
    check("hold_release_valid", 32'(ov), 32'(0));
    exp_q.push_back({1'b0, 16'h3333});
    @(posedge clk); #1;
    get_out(4, ov, ir, res, cy, st, fl);
    check("hold_next_accept", 32'(st), 32'(RUN));
    set_in(4, 1'b0, 16'h1111, 16'h2222, OP_ADD, 1'b0);
    collect(4, 4, 3'b000, "hold_next");

    // Reset during RUN cycle 2 discards the op
    set_in(4, 1'b1, 16'hAAAA, 16'h5555, OP_ADD, 1'b0);
    @(posedge clk); #1;
    set_in(4, 1'b0, 16'hAAAA, 16'h5555, OP_ADD, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    get_out(4, ov, ir, res, cy, st, fl);
    check("midrun_rst_state", 32'(st), 32'(IDLE));
    check("midrun_rst_ready", 32'(ir), 32'(1));
    check("midrun_rst_valid", 32'(ov), 32'(0));
    check("midrun_rst_result", 32'(res), 32'(0));
    check("midrun_rst_carry", 32'(cy), 32'(0));
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      get_out(4, ov, ir, res, cy, st, fl);
      if (ov) seen = 1'b1;
    end
    check("midrun_no_valid", 32'(seen), 32'(0));
    run_vec(4, 10, 4, "post_rst_add");

    // Other slice widths
    run_vec(1, 0, 16, "s1_add_ovf");
    run_vec(1, 7, 16, "s1_illegal");
    run_vec(16, 1, 1, "s16_sub");
    run_vec(16, 7, 1, "s16_illegal");

    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
